// File: rtl/tumble_board.sv
// tumble_board: Turing Tumble style ball board.
// Two ball reservoirs with lever triggers feed a tray, with a bit cell
// (toggle) and an interceptor (latching stop) alongside.
// Optional feature macro: TUMBLE_TRAY_EN. When it is defined the tray
// counter is built. When it is undefined, tray_amount is tied to 0.
// Every output is a register, so each one follows its cause by one cycle.
module tumble_board #(
  parameter int   BLUE_COUNT = 8,
  parameter int   RED_COUNT  = 8,
  parameter int   CNT_W      = 5,
  parameter logic BIT_INIT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blue_trigger,
  input  logic             red_trigger,
  output logic             blue_ball,
  output logic             red_ball,
  output logic             no_balls,
  output logic             current_color,
  output logic [CNT_W-1:0] tray_amount,
  input  logic             bit_in_l,
  input  logic             bit_in_r,
  output logic             bit_out_l,
  output logic             bit_out_r,
  output logic             bit_state,
  input  logic             icpt_in_l,
  input  logic             icpt_in_r,
  output logic             icpt_full,
  output logic             stopped
);

  logic [CNT_W-1:0] r_blueCnt;
  logic [CNT_W-1:0] r_redCnt;
  logic             r_blueBall;
  logic             r_redBall;
  logic             r_noBalls;
  logic             r_icptFull;
  logic             r_stopped;
  logic             r_curColor;
  logic             r_bitState;
  logic             r_bitOutL;
  logic             r_bitOutR;

  logic             w_blueSel;
  logic             w_redSel;
  logic             w_blueRel;
  logic             w_redRel;
  logic             w_empty;
  logic             w_noBallsNext;
  logic             w_icptNext;
  logic             w_bitArrive;

  // Trigger arbitration: blue wins a tie, a stopped board ignores both levers,
  // and a lever that finds its reservoir empty raises the empty condition
  always_comb begin
    w_blueSel     = blue_trigger & ~r_stopped;
    w_redSel      = red_trigger & ~blue_trigger & ~r_stopped;
    w_blueRel     = w_blueSel & (r_blueCnt != '0);
    w_redRel      = w_redSel & (r_redCnt != '0);
    w_empty       = (w_blueSel & (r_blueCnt == '0)) | (w_redSel & (r_redCnt == '0));
    w_noBallsNext = r_noBalls | w_empty;
    w_icptNext    = r_icptFull | icpt_in_l | icpt_in_r;
    w_bitArrive   = bit_in_l | bit_in_r;
  end

  // Reservoirs, release pulses, colour and the sticky stop flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blueCnt  <= CNT_W'(BLUE_COUNT);
      r_redCnt   <= CNT_W'(RED_COUNT);
      r_blueBall <= 1'b0;
      r_redBall  <= 1'b0;
      r_noBalls  <= 1'b0;
      r_icptFull <= 1'b0;
      r_stopped  <= 1'b0;
      r_curColor <= 1'b0;
    end else begin
      r_blueBall <= w_blueRel;
      r_redBall  <= w_redRel;
      r_noBalls  <= w_noBallsNext;
      r_icptFull <= w_icptNext;
      r_stopped  <= w_noBallsNext | w_icptNext;
      if (w_blueRel) begin
        r_blueCnt  <= r_blueCnt - 1'b1;
        r_curColor <= 1'b0;
      end else if (w_redRel) begin
        r_redCnt   <= r_redCnt - 1'b1;
        r_curColor <= 1'b1;
      end
    end
  end

  // Bit cell: a ball from either side flips the state and exits toward the
  // side given by the old state (0 sends right, 1 sends left)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitState <= BIT_INIT;
      r_bitOutL  <= 1'b0;
      r_bitOutR  <= 1'b0;
    end else begin
      r_bitOutL <= w_bitArrive & r_bitState;
      r_bitOutR <= w_bitArrive & ~r_bitState;
      if (w_bitArrive) begin
        r_bitState <= ~r_bitState;
      end
    end
  end

`ifdef TUMBLE_TRAY_EN
  logic [CNT_W-1:0] r_tray;

  // Tray counter: one more ball per release, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tray <= '0;
    end else if ((w_blueRel | w_redRel) && (r_tray != '1)) begin
      r_tray <= r_tray + 1'b1;
    end
  end

  assign tray_amount = r_tray;
`else
  assign tray_amount = '0;
`endif

  assign blue_ball     = r_blueBall;
  assign red_ball      = r_redBall;
  assign no_balls      = r_noBalls;
  assign current_color = r_curColor;
  assign bit_out_l     = r_bitOutL;
  assign bit_out_r     = r_bitOutR;
  assign bit_state     = r_bitState;
  assign icpt_full     = r_icptFull;
  assign stopped       = r_stopped;

endmodule

// File: tb/tb_tumble_board.sv
// tb_tumble_board: directed scenarios followed by random stimulus, with every
// cycle compared against a ball-count model of the board.
module tb_tumble_board;

  localparam int BLUE_N = 6;
  localparam int RED_N  = 2;
  localparam int CW     = 3;
  localparam int TRAY_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          blue_trigger;
  logic          red_trigger;
  logic          blue_ball;
  logic          red_ball;
  logic          no_balls;
  logic          current_color;
  logic [CW-1:0] tray_amount;
  logic          bit_in_l;
  logic          bit_in_r;
  logic          bit_out_l;
  logic          bit_out_r;
  logic          bit_state;
  logic          icpt_in_l;
  logic          icpt_in_r;
  logic          icpt_full;
  logic          stopped;

  int checks;
  int errors;

  // Model state: balls left in each reservoir, balls in the tray, flags
  int mBlue;
  int mRed;
  int mTray;
  bit mNoBalls;
  bit mIcpt;
  bit mColor;
  bit mBit;
  bit mBlueBall;
  bit mRedBall;
  bit mOutL;
  bit mOutR;

  tumble_board #(
    .BLUE_COUNT(BLUE_N),
    .RED_COUNT (RED_N),
    .CNT_W     (CW),
    .BIT_INIT  (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blue_trigger (blue_trigger),
    .red_trigger  (red_trigger),
    .blue_ball    (blue_ball),
    .red_ball     (red_ball),
    .no_balls     (no_balls),
    .current_color(current_color),
    .tray_amount  (tray_amount),
    .bit_in_l     (bit_in_l),
    .bit_in_r     (bit_in_r),
    .bit_out_l    (bit_out_l),
    .bit_out_r    (bit_out_r),
    .bit_state    (bit_state),
    .icpt_in_l    (icpt_in_l),
    .icpt_in_r    (icpt_in_r),
    .icpt_full    (icpt_full),
    .stopped      (stopped)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advances the model by one board step using the rules of play
  task automatic modelStep(input bit r, input bit bt, input bit rt,
                           input bit bl, input bit br, input bit il, input bit ir);
    mBlueBall = 0;
    mRedBall  = 0;
    mOutL     = 0;
    mOutR     = 0;
    if (r) begin
      mBlue    = BLUE_N;
      mRed     = RED_N;
      mTray    = 0;
      mNoBalls = 0;
      mIcpt    = 0;
      mColor   = 0;
      mBit     = 0;
    end else begin
      if (!(mNoBalls || mIcpt)) begin
        if (bt) begin
          if (mBlue > 0) begin
            mBlue--;
            mBlueBall = 1;
            mColor    = 0;
            if (mTray < TRAY_MAX) mTray++;
          end else begin
            mNoBalls = 1;
          end
        end else if (rt) begin
          if (mRed > 0) begin
            mRed--;
            mRedBall = 1;
            mColor   = 1;
            if (mTray < TRAY_MAX) mTray++;
          end else begin
            mNoBalls = 1;
          end
        end
      end
      if (bl || br) begin
        if (mBit) mOutL = 1;
        else      mOutR = 1;
        mBit = !mBit;
      end
      if (il || ir) mIcpt = 1;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit bt, input bit rt,
                               input bit bl, input bit br, input bit il, input bit ir);
    int expTray;
    rst          = r;
    blue_trigger = bt;
    red_trigger  = rt;
    bit_in_l     = bl;
    bit_in_r     = br;
    icpt_in_l    = il;
    icpt_in_r    = ir;
    @(posedge clk);
    #1;
    modelStep(r, bt, rt, bl, br, il, ir);
`ifdef TUMBLE_TRAY_EN
    expTray = mTray;
`else
    expTray = 0;
`endif
    checkOutput("blue_ball",     32'(blue_ball),     32'(mBlueBall));
    checkOutput("red_ball",      32'(red_ball),      32'(mRedBall));
    checkOutput("no_balls",      32'(no_balls),      32'(mNoBalls));
    checkOutput("current_color", 32'(current_color), 32'(mColor));
    checkOutput("tray_amount",   32'(tray_amount),   32'(expTray));
    checkOutput("bit_out_l",     32'(bit_out_l),     32'(mOutL));
    checkOutput("bit_out_r",     32'(bit_out_r),     32'(mOutR));
    checkOutput("bit_state",     32'(bit_state),     32'(mBit));
    checkOutput("icpt_full",     32'(icpt_full),     32'(mIcpt));
    checkOutput("stopped",       32'(stopped),       32'(mNoBalls | mIcpt));
  endtask

  // Directed scenarios first, then a long randomized run with sparse resets
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; blue_trigger = 1'b0; red_trigger = 1'b0;
    bit_in_l = 1'b0; bit_in_r = 1'b0; icpt_in_l = 1'b0; icpt_in_r = 1'b0;

    // Reset, then a single blue lever pulse
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Three red pulses against a two-ball red reservoir
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("empty_red_flag", 32'(no_balls), 32'd1);

    // Bit cell: left, right, left, then a simultaneous pair counts once
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);

    // Interceptor stops the board; later levers and arrivals are absorbed
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);

    // Both levers together: only blue is served
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);

    // Reset right after the interceptor fills, with activity on every input
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 1, 1, 1);
    checkOutput("reset_icpt", 32'(icpt_full), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    // Drain everything so the tray limit is reached
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, (i < 6), (i >= 6), 0, 0, 0, 0);
    end

    // Randomized run
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
